im_boot_ctrl: RTL

Sequencer and arbiter for the CPU's single-port 64-word instruction memory. After Reset, it owns the memory write side and assembles a byte-serial program stream into 32-bit words, writing them sequentially from word 0. When loading completes it releases the CPU (cpu_run) and serves instruction fetches with a registered 1-cycle read response. Sits between the boot/UART loader, the fetch stage and the instruction memory array.

---
 rtl/im_boot_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/im_boot_ctrl.sv
// Boot sequencer and fetch arbiter for the single-port instruction memory.
// Optional IM_RELOAD_EN: reload_req restarts loading from RUN or ERR.
module im_boot_ctrl #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              ld_valid,
    input  logic [7:0]        ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic              reload_req,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_pc,
    output logic              fetch_valid,
    output logic [31:0]       fetch_instr,
    output logic              fetch_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              cpu_run,
    output logic [ADDR_W:0]   load_count,
    output logic              err_overflow
);

    typedef enum logic [1:0] {S_LOAD, S_WRITE, S_RUN, S_ERR} state_t;

    state_t              r_state, w_next;
    logic                r_ld_ready;
    logic [ADDR_W:0]     r_load_count;
    logic [1:0]          r_byte_idx;
    logic [31:0]         r_word;
    logic                r_last;
    logic                r_err;
    logic                r_fetch_valid, r_fetch_err;
    logic [31:0]         r_fetch_instr;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [31:0]         r_mem_wdata;
    logic                w_accept, w_full, w_fetch_bad, w_reload;

    assign w_accept    = ld_valid & r_ld_ready;
    assign w_full      = (r_load_count == (ADDR_W+1)'(DEPTH));
    assign w_fetch_bad = (|fetch_pc[1:0]) | (|fetch_pc[31:ADDR_W+2]);

`ifdef IM_RELOAD_EN
    assign w_reload = reload_req;
`else
    assign w_reload = 1'b0 & reload_req;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) r_state <= S_LOAD;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LOAD: begin
                if (w_accept) begin
                    if (w_full)                          w_next = S_ERR;
                    else if (r_byte_idx == 2'd3 || ld_last) w_next = S_WRITE;
                end
            end
            S_WRITE: w_next = r_last ? S_RUN : S_LOAD;
            S_RUN:   if (w_reload) w_next = S_LOAD;
            S_ERR:   if (w_reload) w_next = S_LOAD;
            default: w_next = S_LOAD;
        endcase
    end

    // Address/data fall back to their registered copies so they hold when idle.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = r_mem_addr;
        mem_wdata = r_mem_wdata;
        cpu_run   = (r_state == S_RUN);
        if (r_state == S_WRITE) begin
            mem_we    = 1'b1;
            mem_addr  = r_load_count[ADDR_W-1:0];
            mem_wdata = r_word;
        end else if (r_state == S_RUN && fetch_req) begin
            mem_addr = fetch_pc[ADDR_W+1:2];
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_ld_ready    <= 1'b0;
            r_load_count  <= '0;
            r_byte_idx    <= '0;
            r_word        <= '0;
            r_last        <= 1'b0;
            r_err         <= 1'b0;
            r_fetch_valid <= 1'b0;
            r_fetch_err   <= 1'b0;
            r_fetch_instr <= '0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
        end else begin
            r_ld_ready    <= (w_next == S_LOAD);
            r_mem_addr    <= mem_addr;
            r_mem_wdata   <= mem_wdata;
            r_fetch_valid <= 1'b0;
            r_fetch_err   <= 1'b0;
            if (r_state == S_RUN && fetch_req) begin
                if (w_fetch_bad) begin
                    r_fetch_err <= 1'b1;
                end else begin
                    r_fetch_valid <= 1'b1;
                    r_fetch_instr <= mem_rdata;
                end
            end
            case (r_state)
                S_LOAD: begin
                    if (w_accept && w_full) begin
                        r_err <= 1'b1;
                    end else if (w_accept) begin
                        r_word[{r_byte_idx, 3'b000} +: 8] <= ld_data;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        r_last     <= ld_last;
                    end
                end
                S_WRITE: begin
                    r_load_count <= r_load_count + (ADDR_W+1)'(1);
                    r_word       <= '0;
                    r_byte_idx   <= '0;
                    r_last       <= 1'b0;
                end
                S_RUN, S_ERR: begin
                    if (w_reload) begin
                        r_err        <= 1'b0;
                        r_load_count <= '0;
                        r_byte_idx   <= '0;
                        r_word       <= '0;
                        r_last       <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ld_ready     = r_ld_ready;
    assign load_count   = r_load_count;
    assign err_overflow = r_err;
    assign fetch_valid  = r_fetch_valid;
    assign fetch_err    = r_fetch_err;
    assign fetch_instr  = r_fetch_instr;

endmodule
